router_fsm: RTL and testbench

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_fsm.sv | 116 +++++++++++
 tb/tb_router_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Packet-router control FSM: decodes the header address and sequences the
// header, payload and parity loads toward the selected output FIFO.
module router_fsm (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty0,
  input  logic       fifo_empty1,
  input  logic       fifo_empty2,
  input  logic       sft_rst0,
  input  logic       sft_rst1,
  input  logic       sft_rst2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       write_en_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] empty_vec, sft_vec;

  logic detect_addr_q, lfd_state_q, ld_state_q, full_state_q, laf_state_q;
  logic write_en_reg_q, rst_int_reg_q, busy_q;

  // Address 3 maps to a tied-off slot so it never selects a FIFO.
  assign empty_vec = {1'b0, fifo_empty2, fifo_empty1, fifo_empty0};
  assign sft_vec   = {1'b0, sft_rst2, sft_rst1, sft_rst0};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          addr_d = data_in;
          if (data_in != 2'd3)
            state_d = empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY:    if (empty_vec[addr_q]) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE:    if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
    endcase
    // Soft reset of the currently selected FIFO abandons the packet.
    if (sft_vec[addr_q]) state_d = DECODE_ADDRESS;
  end

  // Outputs are registered from the next state so they always match state_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= DECODE_ADDRESS;
      addr_q         <= 2'd0;
      detect_addr_q  <= 1'b1;
      lfd_state_q    <= 1'b0;
      ld_state_q     <= 1'b0;
      full_state_q   <= 1'b0;
      laf_state_q    <= 1'b0;
      write_en_reg_q <= 1'b0;
      rst_int_reg_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      detect_addr_q  <= (state_d == DECODE_ADDRESS);
      lfd_state_q    <= (state_d == LOAD_FIRST_DATA);
      ld_state_q     <= (state_d == LOAD_DATA);
      full_state_q   <= (state_d == FIFO_FULL_STATE);
      laf_state_q    <= (state_d == LOAD_AFTER_FULL);
      write_en_reg_q <= (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                        (state_d == LOAD_AFTER_FULL);
      rst_int_reg_q  <= (state_d == CHECK_PARITY_ERROR);
      busy_q         <= !((state_d == DECODE_ADDRESS) || (state_d == LOAD_DATA));
    end
  end

  assign detect_addr  = detect_addr_q;
  assign lfd_state    = lfd_state_q;
  assign ld_state     = ld_state_q;
  assign full_state   = full_state_q;
  assign laf_state    = laf_state_q;
  assign write_en_reg = write_en_reg_q;
  assign rst_int_reg  = rst_int_reg_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: a rule-level reference model checked every
// cycle, plus literal output expectations at key points of each scenario.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty0, fifo_empty1, fifo_empty2;
  logic       sft_rst0, sft_rst1, sft_rst2;
  logic       parity_done, low_pkt_valid;
  logic       detect_addr, lfd_state, ld_state, full_state, laf_state;
  logic       write_en_reg, rst_int_reg, busy;

  int total = 0;
  int bad   = 0;

  router_fsm dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
    .fifo_empty2(fifo_empty2), .sft_rst0(sft_rst0), .sft_rst1(sft_rst1),
    .sft_rst2(sft_rst2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .write_en_reg(write_en_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output bundle order: detect, lfd, ld, full, laf, rst_int, write_en, busy.
  logic [7:0] outs;
  assign outs = {detect_addr, lfd_state, ld_state, full_state, laf_state,
                 rst_int_reg, write_en_reg, busy};

  // Reference model: phase names and the output rules stated per phase.
  string      ms;
  logic [1:0] maddr;

  function automatic logic [7:0] model_out(input string s);
    logic we, bz;
    we = (s == "LD") || (s == "LP") || (s == "LAF");
    bz = !((s == "DA") || (s == "LD"));
    return {s == "DA", s == "LFD", s == "LD", s == "FULL", s == "LAF",
            s == "CPE", we, bz};
  endfunction

  initial begin
    string      ns;
    logic [3:0] emp, sft;
    ms    = "DA";
    maddr = 2'd0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        ms    = "DA";
        maddr = 2'd0;
      end else begin
        emp = {1'b0, fifo_empty2, fifo_empty1, fifo_empty0};
        sft = {1'b0, sft_rst2, sft_rst1, sft_rst0};
        ns  = ms;
        case (ms)
          "DA":   if (pkt_valid && data_in != 2'd3) ns = emp[data_in] ? "LFD" : "WTE";
          "WTE":  if (emp[maddr]) ns = "LFD";
          "LFD":  ns = "LD";
          "LD":   if (fifo_full) ns = "FULL"; else if (!pkt_valid) ns = "LP";
          "FULL": if (!fifo_full) ns = "LAF";
          "LAF":  ns = parity_done ? "DA" : (low_pkt_valid ? "LP" : "LD");
          "LP":   ns = "CPE";
          "CPE":  ns = fifo_full ? "FULL" : "DA";
          default: ns = "DA";
        endcase
        if (sft[maddr]) ns = "DA";
        if (ms == "DA" && pkt_valid) maddr = data_in;
        ms = ns;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      total++;
      if (outs !== model_out(ms)) begin
        bad++;
        $display("FAIL cycle_model t=%0t phase=%s: got %b want %b", $time, ms, outs, model_out(ms));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] exp);
    total++;
    if (outs !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, outs, exp);
    end else begin
      $display("ok   %s: outs=%b", name, outs);
    end
  endtask

  localparam logic [7:0] O_DA   = 8'b1000_0000;
  localparam logic [7:0] O_WTE  = 8'b0000_0001;
  localparam logic [7:0] O_LFD  = 8'b0100_0001;
  localparam logic [7:0] O_LD   = 8'b0010_0010;
  localparam logic [7:0] O_FULL = 8'b0001_0001;
  localparam logic [7:0] O_LAF  = 8'b0000_1011;
  localparam logic [7:0] O_LP   = 8'b0000_0011;
  localparam logic [7:0] O_CPE  = 8'b0000_0101;

  initial begin
    rstn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty0 = 1'b1; fifo_empty1 = 1'b1; fifo_empty2 = 1'b1;
    sft_rst0 = 1'b0; sft_rst1 = 1'b0; sft_rst2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    #12;
    chk("reset_state", O_DA);
    rstn = 1'b1;

    // Normal packet to FIFO 1 with three payload cycles.
    pkt_valid = 1'b1; data_in = 2'd1;
    tick(); chk("norm_lfd", O_LFD);
    data_in = 2'd0;
    tick(); chk("norm_ld1", O_LD);
    tick(); chk("norm_ld2", O_LD);
    tick(); chk("norm_ld3", O_LD);
    pkt_valid = 1'b0;
    tick(); chk("norm_lp", O_LP);
    tick(); chk("norm_cpe", O_CPE);
    tick(); chk("norm_da", O_DA);
    tick(); chk("idle_da", O_DA);

    // Wait for FIFO 2 to drain for four cycles.
    fifo_empty2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("wait_wte%0d", i), O_WTE);
    end
    fifo_empty2 = 1'b1;
    tick(); chk("wait_lfd", O_LFD);
    tick(); chk("wait_ld", O_LD);

    // FIFO full during payload, resume to LOAD_DATA.
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("full%0d", i), O_FULL);
    end
    fifo_full = 1'b0;
    tick(); chk("full_laf", O_LAF);
    tick(); chk("laf_to_ld", O_LD);

    // Full again, then low_pkt_valid steers to parity load.
    fifo_full = 1'b1;
    tick(); chk("full_b", O_FULL);
    fifo_full = 1'b0;
    tick(); chk("laf_b", O_LAF);
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    tick(); chk("laf_to_lp", O_LP);
    low_pkt_valid = 1'b0; fifo_full = 1'b1;
    tick(); chk("lp_cpe", O_CPE);
    tick(); chk("cpe_to_full", O_FULL);
    fifo_full = 1'b0;
    tick(); chk("laf_c", O_LAF);
    parity_done = 1'b1;
    tick(); chk("laf_parity_done_da", O_DA);
    parity_done = 1'b0;

    // Soft reset: only the selected FIFO's soft reset counts.
    pkt_valid = 1'b1; data_in = 2'd0;
    tick(); chk("sft_lfd", O_LFD);
    tick(); chk("sft_ld", O_LD);
    fifo_full = 1'b1;
    tick(); chk("sft_full", O_FULL);
    sft_rst1 = 1'b1;
    tick(); chk("sft_other_ignored", O_FULL);
    sft_rst1 = 1'b0; sft_rst0 = 1'b1;
    tick(); chk("sft_selected_da", O_DA);
    sft_rst0 = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0;
    tick(); chk("sft_idle", O_DA);

    // Invalid address 3 stays in decode.
    pkt_valid = 1'b1; data_in = 2'd3;
    tick(); chk("inv_da1", O_DA);
    tick(); chk("inv_da2", O_DA);
    pkt_valid = 1'b0;

    // Asynchronous reset in the middle of LOAD_DATA.
    pkt_valid = 1'b1; data_in = 2'd1;
    tick(); chk("ar_lfd", O_LFD);
    tick(); chk("ar_ld", O_LD);
    #1 rstn = 1'b0;
    #1 chk("async_reset_da", O_DA);
    pkt_valid = 1'b0;
    tick(); chk("reset_held_da", O_DA);
    rstn = 1'b1;
    tick(); chk("post_reset_da", O_DA);
    pkt_valid = 1'b1; data_in = 2'd2;
    tick(); chk("post_reset_lfd", O_LFD);
    pkt_valid = 1'b0;
    tick(); chk("post_reset_ld", O_LD);
    tick(); chk("post_reset_lp", O_LP);
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
